// File: rtl/out_stream_tx_pkg.sv
// out_stream_tx_pkg: shared definitions for the program-output transmitter.
//   - FSM state encodings for the req/ack handshake
//   - default FIFO depth and data width
// Optional feature macro: OUT_STREAM_ACK_SYNC_EN
//   When defined, host_ack passes through a 2-flop synchronizer in
//   out_stream_tx before the FSM sees it (adds 2 cycles of ack latency).
//   When undefined, host_ack feeds the FSM directly.
package out_stream_tx_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

endpackage

// File: rtl/out_stream_tx_sync_fifo.sv
// out_stream_tx_sync_fifo: single-clock FIFO with registered occupancy.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, wdata     write request and data; accepted when not full, or
//                   when a pop happens in the same cycle
//   pop             read request; ignored when empty
//   rdata           current head entry (valid when !empty)
//   full, empty     occupancy flags derived from level
//   level           number of stored entries, 0..DEPTH
//   push_ok         push was accepted this cycle
module out_stream_tx_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 3,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  level,
  output logic              push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         pop_ok;

  assign full    = (level == CNT_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/out_stream_tx.sv
// out_stream_tx: buffers the execute unit's program-output values and sends
// them off-chip over a 4-phase req/ack handshake.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   out_valid       one-cycle strobe, out_data holds a new value
//   out_data        program output value
//   halt            execute unit halted (may stay high)
//   host_ack        host acknowledge pin
//   tx_req          transmit request, high exactly in REQ
//   tx_data         value on the wire, stable while tx_req=1
//   level           FIFO occupancy
//   overflow        sticky, a value was dropped on a full FIFO
//   done            halt seen, FIFO empty, no transfer in flight
// Optional feature macro: OUT_STREAM_ACK_SYNC_EN (2-flop ack synchronizer).
module out_stream_tx
  import out_stream_tx_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  input  logic              halt,
  input  logic              host_ack,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  output logic              done
);

  state_e             state;
  logic               halt_seen;
  logic               ack_s;
  logic               pop;
  logic               full, empty, push_ok;
  logic [DATA_W-1:0]  head;

  // The head is loaded into tx_data in the same cycle it is popped.
  assign pop = (state == ST_IDLE) & ~empty;

  out_stream_tx_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (out_valid),
    .wdata   (out_data),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .push_ok (push_ok)
  );

`ifdef OUT_STREAM_ACK_SYNC_EN
  logic [1:0] ack_sync;
  always_ff @(posedge clk) begin
    if (!rst_n) ack_sync <= 2'b00;
    else        ack_sync <= {ack_sync[0], host_ack};
  end
  assign ack_s = ack_sync[1];
`else
  assign ack_s = host_ack;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_seen <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (halt) halt_seen <= 1'b1;
      if (out_valid & ~push_ok) overflow <= 1'b1;
      // A push after halt is not expected, but it still clears done.
      done <= halt_seen & empty & (state == ST_IDLE) & ~out_valid;
    end
  end

  // REL waits for ack low, so an ack held high never triggers a repeat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx_req  <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!empty) begin
          tx_data <= head;
          tx_req  <= 1'b1;
          state   <= ST_REQ;
        end
        ST_REQ: if (ack_s) begin
          tx_req <= 1'b0;
          state  <= ST_REL;
        end
        ST_REL: if (!ack_s) state <= ST_IDLE;
        default: begin
          tx_req <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_stream_tx.sv
// Bench for out_stream_tx: a host model acks requests and checks every
// transmitted value against a scoreboard filled as values are pushed.
module tb_out_stream_tx;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 3;
  localparam int CNT_W  = 4;
`ifdef OUT_STREAM_ACK_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              out_valid = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic              halt = 1'b0;
  logic              host_ack = 1'b0;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  level;
  logic              overflow;
  logic              done;

  out_stream_tx #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_valid (out_valid),
    .out_data  (out_data),
    .halt      (halt),
    .host_ack  (host_ack),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .level     (level),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb[$];

  // host model state: mode 0 = ack after ack_dly, drop when req falls;
  // mode 1 = never ack; mode 2 = ack and hold high
  int xfers = 0;
  int cyc = 0;
  int host_mode = 0;
  int ack_dly = 2;
  int wait_cnt = 0;
  int ack_cyc = 0;
  bit ack_pend = 1'b0;
  bit prev_req = 1'b0;
  logic [DATA_W-1:0] cur_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (tx_req === 1'b1 && !prev_req) begin
      xfers++;
      cur_data = tx_data;
      wait_cnt = 0;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got data %0d expected no transfer", tx_data);
      end else begin
        check("xfer_data", 32'(tx_data), 32'(sb.pop_front()));
      end
    end else if (tx_req === 1'b1) begin
      check("data_stable", 32'(tx_data), 32'(cur_data));
    end
    if (tx_req !== 1'b1 && prev_req && ack_pend) begin
      check("ack_lat", cyc - ack_cyc, ACK_LAT);
      ack_pend = 1'b0;
    end
    prev_req = (tx_req === 1'b1);
    case (host_mode)
      0: begin
        if (tx_req === 1'b1 && !host_ack) begin
          if (wait_cnt >= ack_dly) begin
            host_ack = 1'b1;
            ack_cyc  = cyc;
            ack_pend = 1'b1;
          end else begin
            wait_cnt++;
          end
        end else if (tx_req !== 1'b1 && host_ack) begin
          host_ack = 1'b0;
        end
      end
      2: if (tx_req === 1'b1 && !host_ack) begin
        host_ack = 1'b1;
        ack_cyc  = cyc;
        ack_pend = 1'b1;
      end
      default: ;
    endcase
  end

  // stimulus moves 1 time unit after the host model's negedge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input bit accept);
    out_valid = 1'b1;
    out_data  = d;
    if (accept) sb.push_back(d);
    tick();
    out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_req !== 1'b0 || host_ack !== 1'b0) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 400), 1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                dly;
    logic [CNT_W-1:0]  exp_lvl;
    int                exp_xf;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   x0;
    int   n;

    vecs[0] = '{3'd5, 2, 4'd1, 1};
    vecs[1] = '{3'd0, 0, 4'd1, 1};
    vecs[2] = '{3'd7, 5, 4'd1, 1};
    vecs[3] = '{3'd2, 1, 4'd1, 1};

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_tx_req",   32'(tx_req),   0);
    check("rst_tx_data",  32'(tx_data),  0);
    check("rst_level",    32'(level),    0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_done",     32'(done),     0);

    // single-value transfers with varying host latency
    host_mode = 0;
    foreach (vecs[i]) begin
      ack_dly = vecs[i].dly;
      x0 = xfers;
      push(vecs[i].data, 1'b1);
      check("single_lvl_push", 32'(level), 32'(vecs[i].exp_lvl));
      wait_idle("single");
      check("single_lvl_end", 32'(level), 0);
      check("single_xfers", xfers - x0, vecs[i].exp_xf);
    end
    ack_dly = 2;

    // ack held high: FSM parks in REL, FIFO fills without popping
    host_mode = 2;
    x0 = xfers;
    push(3'd3, 1'b1);
    repeat (6) tick();
    check("park_tx_req", 32'(tx_req), 0);
    check("park_xfers", xfers - x0, 1);
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(i), 1'b1);
    check("fill_level", 32'(level), DEPTH);
    check("fill_overflow", 32'(overflow), 0);
    check("fill_tx_req", 32'(tx_req), 0);
    check("fill_xfers", xfers - x0, 1);

    // release ack; push lands exactly in the cycle IDLE pops the full FIFO
    host_mode = 0;
    repeat (ACK_LAT + 1) tick();
    check("pre_pop_level", 32'(level), DEPTH);
    push(3'd6, 1'b1);
    check("pushpop_level", 32'(level), DEPTH);
    check("pushpop_overflow", 32'(overflow), 0);
    wait_idle("pushpop");
    check("pushpop_xfers", xfers - x0, 10);
    check("pushpop_lvl_end", 32'(level), 0);

    // overflow: a push into a full, non-popping FIFO is dropped
    host_mode = 2;
    x0 = xfers;
    push(3'd2, 1'b1);
    repeat (6) tick();
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(7 - i), 1'b1);
    push(3'd1, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_level", 32'(level), DEPTH);
    host_mode = 0;
    wait_idle("ovf");
    check("ovf_xfers", xfers - x0, 9);
    check("ovf_lvl_end", 32'(level), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // halt/done
    do_reset();
    check("rst2_overflow", 32'(overflow), 0);
    x0 = xfers;
    push(3'd4, 1'b1);
    push(3'd2, 1'b1);
    halt = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (xfers - x0 < 2 || tx_req === 1'b1 || host_ack) check("done_early", 32'(done), 0);
      tick();
      n++;
    end
    check("done_set", 32'(done), 1);
    check("done_xfers", xfers - x0, 2);
    check("done_tx_req", 32'(tx_req), 0);
    repeat (3) tick();
    check("done_hold", 32'(done), 1);
    push(3'd5, 1'b1);
    check("done_clr_push", 32'(done), 0);
    wait_idle("late");

    // reset in the middle of REQ
    host_mode = 1;
    push(3'd6, 1'b1);
    tick();
    check("midreq_req", 32'(tx_req), 1);
    do_reset();
    check("midreq_rst_req", 32'(tx_req), 0);
    check("midreq_rst_done", 32'(done), 0);
    check("midreq_rst_level", 32'(level), 0);
    halt = 1'b0;
    host_mode = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
